// File: rtl/serial_tx_scheduler.sv
// Round-robin packet arbiter for the avionics serial link. Each granted producer
// packet is framed as SYNC, ID, LEN, payload, checksum and paced against tx_busy.
module serial_tx_scheduler #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_len,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]   src_rd,
  output logic [NUM_SRC-1:0]   src_done,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy
);

  localparam int IDXW = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SRC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_ID,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_GAP
  } state_t;

  state_t          state, state_nxt;
  state_t          ret, ret_nxt;
  state_t          byte_ret;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [7:0]      len, len_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [7:0]      csum, csum_nxt;

  logic            arb_found;
  logic [IDXW-1:0] arb_idx;
  logic [IDXW:0]   arb_sum;

  logic            send;
  logic            strobe;
  logic [7:0]      byte_val;
  logic            rd_pulse;
  logic            done_pulse;

  logic [7:0]         cur_data;
  logic [7:0]         id_byte;
  logic [NUM_SRC-1:0] idx_onehot;

  assign cur_data   = src_data[{idx, 3'b000} +: 8];
  assign id_byte    = 8'(idx);
  assign idx_onehot = NUM_SRC'(1) << idx;

  // First requester at or after ptr, scanning upward with wrap-around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      arb_sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (arb_sum >= (IDXW+1)'(NUM_SRC)) begin
        arb_sum = arb_sum - (IDXW+1)'(NUM_SRC);
      end
      if (!arb_found && src_req[arb_sum[IDXW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret;
    idx_nxt    = idx;
    ptr_nxt    = ptr;
    len_nxt    = len;
    cnt_nxt    = cnt;
    csum_nxt   = csum;
    send       = 1'b0;
    byte_val   = 8'h00;
    byte_ret   = S_IDLE;
    rd_pulse   = 1'b0;
    done_pulse = 1'b0;
    strobe     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (enable && arb_found) begin
          idx_nxt   = arb_idx;
          len_nxt   = src_len[{arb_idx, 3'b000} +: 8];
          cnt_nxt   = 8'h00;
          csum_nxt  = 8'h00;
          ptr_nxt   = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
          state_nxt = S_SYNC;
        end
      end
      S_SYNC: begin
        send     = 1'b1;
        byte_val = SYNC_BYTE;
        byte_ret = S_ID;
      end
      S_ID: begin
        send     = 1'b1;
        byte_val = id_byte;
        byte_ret = S_LEN;
      end
      S_LEN: begin
        send     = 1'b1;
        byte_val = len;
        byte_ret = (len == 8'h00) ? S_CSUM : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        send     = 1'b1;
        byte_val = cur_data;
        byte_ret = (cnt == len - 8'd1) ? S_CSUM : S_PAYLOAD;
      end
      S_CSUM: begin
        send     = 1'b1;
        byte_val = csum;
        byte_ret = S_IDLE;
      end
      S_GAP: begin
        state_nxt  = ret;
        done_pulse = (ret == S_IDLE);
      end
      default: state_nxt = S_IDLE;
    endcase

    // GAP absorbs the transmitter's one-cycle busy latency after every strobe.
    strobe = send && !tx_busy;
    if (strobe) begin
      state_nxt = S_GAP;
      ret_nxt   = byte_ret;
      if (state != S_SYNC && state != S_CSUM) begin
        csum_nxt = csum ^ byte_val;
      end
      if (state == S_PAYLOAD) begin
        cnt_nxt  = cnt + 8'd1;
        rd_pulse = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ret   <= S_IDLE;
      idx   <= '0;
      ptr   <= '0;
      len   <= 8'h00;
      cnt   <= 8'h00;
      csum  <= 8'h00;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      idx   <= idx_nxt;
      ptr   <= ptr_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
      csum  <= csum_nxt;
    end
  end

  // Strobes are masked while rst is high so an abandoned frame emits nothing more.
  assign busy        = (state != S_IDLE);
  assign grant       = busy ? idx_onehot : '0;
  assign new_tx_data = strobe && !rst;
  assign tx_data     = new_tx_data ? byte_val : 8'h00;
  assign src_rd      = (rd_pulse && !rst) ? idx_onehot : '0;
  assign src_done    = (done_pulse && !rst) ? idx_onehot : '0;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Self-checking bench for serial_tx_scheduler: a source model feeds packets and a
// negedge monitor pops an expected-byte/expected-source scoreboard.
module tb_serial_tx_scheduler;

  localparam int NUM_SRC = 4;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [NUM_SRC-1:0]   src_req;
  logic [8*NUM_SRC-1:0] src_len;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_rd;
  logic [NUM_SRC-1:0]   src_done;
  logic [NUM_SRC-1:0]   grant;
  logic                 busy;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_bytes[$];
  int         exp_src[$];

  logic [7:0]         pkt [NUM_SRC][256];
  int                 pkt_len [NUM_SRC];
  int                 pos [NUM_SRC];
  int                 req_cnt [NUM_SRC];
  int                 rd_count [NUM_SRC];
  int                 done_count [NUM_SRC];
  logic [NUM_SRC-1:0] rd_seen = '0;
  logic [NUM_SRC-1:0] done_seen = '0;

  int cyc = 0;
  int last_strobe = 0;
  int frame_strobes = 0;
  bit exact_spacing = 0;

  serial_tx_scheduler #(.NUM_SRC(NUM_SRC), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .src_req    (src_req),
    .src_len    (src_len),
    .src_data   (src_data),
    .src_rd     (src_rd),
    .src_done   (src_done),
    .grant      (grant),
    .busy       (busy),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .tx_busy    (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Producer model: advances its byte pointer after each src_rd, retires a packet on src_done.
  initial begin
    src_req  = '0;
    src_len  = '0;
    src_data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rd_seen[i]) begin
          pos[i]++;
          rd_seen[i] = 1'b0;
        end
        if (done_seen[i]) begin
          if (req_cnt[i] > 0) req_cnt[i]--;
          pos[i] = 0;
          done_seen[i] = 1'b0;
        end
        src_req[i] = (req_cnt[i] > 0);
        src_len[8*i +: 8] = 8'(pkt_len[i]);
        src_data[8*i +: 8] = pkt[i][(pos[i] > 255) ? 255 : pos[i]];
      end
    end
  end

  initial begin : monitor
    logic [7:0]         eb;
    logic [NUM_SRC-1:0] oh;
    forever begin
      @(negedge clk);
      cyc++;
      if (new_tx_data === 1'b1) begin
        total++;
        if (tx_busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL strobe_busy: new_tx_data=1 while tx_busy=%b, required no strobe", tx_busy);
        end
        if (frame_strobes > 0) begin
          total++;
          if ((cyc - last_strobe) < 2 || (exact_spacing && (cyc - last_strobe) != 2)) begin
            bad++;
            $display("[TB] FAIL strobe_spacing: got %0d cycles, required %s2", cyc - last_strobe,
                     exact_spacing ? "" : ">=");
          end
        end
        last_strobe = cyc;
        frame_strobes++;
        total++;
        if (exp_bytes.size() == 0) begin
          bad++;
          $display("[TB] FAIL tx_byte: got 0x%02h, required no strobe", tx_data);
        end else begin
          eb = exp_bytes.pop_front();
          if (tx_data !== eb) begin
            bad++;
            $display("[TB] FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data, eb);
          end
        end
      end
      total++;
      if (busy === 1'b1) begin
        if (exp_src.size() == 0) begin
          bad++;
          $display("[TB] FAIL grant: got %b while busy, required no frame", grant);
        end else begin
          oh = '0;
          oh[exp_src[0]] = 1'b1;
          if (grant !== oh) begin
            bad++;
            $display("[TB] FAIL grant: got %b, required %b", grant, oh);
          end
        end
      end else if (grant !== '0) begin
        bad++;
        $display("[TB] FAIL grant_idle: got %b, required 0", grant);
      end
      if (src_rd !== '0) begin
        total++;
        if (src_rd !== grant) begin
          bad++;
          $display("[TB] FAIL src_rd: got %b, required %b", src_rd, grant);
        end
        for (int i = 0; i < NUM_SRC; i++) if (src_rd[i]) rd_count[i]++;
        rd_seen |= src_rd;
      end
      if (src_done !== '0) begin
        total++;
        if (exp_src.size() == 0) begin
          bad++;
          $display("[TB] FAIL src_done: got %b, required none", src_done);
        end else begin
          oh = '0;
          oh[exp_src[0]] = 1'b1;
          if (src_done !== oh) begin
            bad++;
            $display("[TB] FAIL src_done: got %b, required %b", src_done, oh);
          end
          exp_src.delete(0);
        end
        for (int i = 0; i < NUM_SRC; i++) if (src_done[i]) done_count[i]++;
        done_seen |= src_done;
        frame_strobes = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setup_pkt(input int s, input int len);
    pkt_len[s] = len;
    for (int k = 0; k < len; k++) pkt[s][k] = 8'($urandom_range(0, 255));
    pos[s] = 0;
  endtask

  task automatic push_frame(input int s);
    logic [7:0] c;
    c = 8'(s) ^ 8'(pkt_len[s]);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'(s));
    exp_bytes.push_back(8'(pkt_len[s]));
    for (int k = 0; k < pkt_len[s]; k++) begin
      exp_bytes.push_back(pkt[s][k]);
      c = c ^ pkt[s][k];
    end
    exp_bytes.push_back(c);
    exp_src.push_back(s);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #1;
      if (exp_bytes.size() == 0 && exp_src.size() == 0 && busy === 1'b0 && src_req == '0) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s: timeout with %0d bytes and %0d frames outstanding, required 0",
               name, exp_bytes.size(), exp_src.size());
    end
    tick();
  endtask

  task automatic wait_strobes(input string name, input int n, input int budget);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (frame_strobes == n) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s: got %0d strobes, required %0d", name, frame_strobes, n);
    end
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    total++;
    if ({busy, grant, tx_data, new_tx_data, src_rd, src_done} !== '0) begin
      bad++;
      $display("[TB] FAIL %s: busy=%b grant=%b tx_data=%02h new=%b rd=%b done=%b, required all 0",
               name, busy, grant, tx_data, new_tx_data, src_rd, src_done);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    total++;
    if (grant !== '0) begin bad++; $display("[TB] FAIL reset_grant: got %b, required 0", grant); end
    total++;
    if (tx_data !== 8'h00 || new_tx_data !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_tx: got data=%02h new=%b, required 00/0", tx_data, new_tx_data);
    end
    total++;
    if (src_rd !== '0 || src_done !== '0) begin
      bad++;
      $display("[TB] FAIL reset_src: got rd=%b done=%b, required 0/0", src_rd, src_done);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    pkt_len[1] = 2;
    pkt[1][0] = 8'h11;
    pkt[1][1] = 8'h22;
    pos[1] = 0;
    rd_count[1] = 0;
    done_count[1] = 0;
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    exp_bytes.push_back(8'h30);
    exp_src.push_back(1);
    exact_spacing = 1;
    enable = 1'b1;
    req_cnt[1] = 1;
    wait_idle("single_frame", 200);
    exact_spacing = 0;
    total++;
    if (rd_count[1] != 2) begin
      bad++;
      $display("[TB] FAIL single_rd_count: got %0d, required 2", rd_count[1]);
    end
    total++;
    if (done_count[1] != 1) begin
      bad++;
      $display("[TB] FAIL single_done_count: got %0d, required 1", done_count[1]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    setup_pkt(0, 3);
    setup_pkt(2, 2);
    push_frame(0);
    push_frame(2);
    push_frame(0);
    push_frame(2);
    req_cnt[0] = 2;
    req_cnt[2] = 2;
    wait_idle("round_robin", 400);
  endtask

  task automatic test_zero_len();
    rd_count[3] = 0;
    done_count[3] = 0;
    setup_pkt(3, 0);
    push_frame(3);
    req_cnt[3] = 1;
    wait_idle("zero_len", 200);
    total++;
    if (rd_count[3] != 0) begin
      bad++;
      $display("[TB] FAIL zero_len_rd: got %0d, required 0", rd_count[3]);
    end
    total++;
    if (done_count[3] != 1) begin
      bad++;
      $display("[TB] FAIL zero_len_done: got %0d, required 1", done_count[3]);
    end
  endtask

  task automatic test_backpressure();
    setup_pkt(1, 3);
    push_frame(1);
    req_cnt[1] = 1;
    wait_strobes("bp_reach_id", 2, 100);
    tick();
    tx_busy = 1'b1;
    repeat (50) tick();
    tx_busy = 1'b0;
    @(negedge clk);
    total++;
    if (new_tx_data !== 1'b1 || tx_data !== 8'd3) begin
      bad++;
      $display("[TB] FAIL bp_len_release: got new=%b data=%02h, required 1/03", new_tx_data, tx_data);
    end
    wait_idle("backpressure", 300);
  endtask

  task automatic test_reset_mid();
    setup_pkt(2, 8);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h08);
    for (int k = 0; k < 3; k++) exp_bytes.push_back(pkt[2][k]);
    exp_src.push_back(2);
    req_cnt[2] = 1;
    wait_strobes("rm_reach_p2", 6, 100);
    tick();
    rst = 1'b1;
    req_cnt[2] = 0;
    pos[2] = 0;
    setup_pkt(0, 2);
    setup_pkt(3, 1);
    push_frame(0);
    push_frame(3);
    req_cnt[0] = 1;
    req_cnt[3] = 1;
    tick();
    rst = 1'b0;
    exp_src.delete(0);
    frame_strobes = 0;
    check_all_zero("reset_mid_outputs");
    wait_idle("reset_mid_next", 300);
  endtask

  task automatic test_enable();
    enable = 1'b0;
    setup_pkt(1, 2);
    push_frame(1);
    req_cnt[1] = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL enable_gate_busy: got %b at cycle %0d, required 0", busy, c);
      end
    end
    tick();
    enable = 1'b1;
    wait_idle("enable_release", 200);

    setup_pkt(0, 4);
    push_frame(0);
    push_frame(0);
    req_cnt[0] = 2;
    wait_strobes("en_mid_sync", 1, 100);
    tick();
    enable = 1'b0;
    begin
      bit ok = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        #1;
        if (exp_src.size() == 1) begin
          ok = 1;
          break;
        end
      end
      total++;
      if (!ok) begin
        bad++;
        $display("[TB] FAIL enable_mid_complete: got %0d frames pending, required 1", exp_src.size());
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL enable_no_regrant: got busy=%b at cycle %0d, required 0", busy, c);
      end
    end
    tick();
    enable = 1'b1;
    wait_idle("enable_second", 200);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    tx_busy = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pkt_len[i] = 0;
      pos[i] = 0;
      req_cnt[i] = 0;
      rd_count[i] = 0;
      done_count[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
